// File: rtl/seat_pkg.sv
// -----------------------------------------------------------------------------
// seat_pkg
// Shared definitions for the seat-table reader: table geometry, field widths,
// the effective seat-state encoding and the reader FSM state type.
// -----------------------------------------------------------------------------
package seat_pkg;

    localparam int NUM_SEATS  = 32;
    localparam int SEAT_IDX_W = $clog2(NUM_SEATS);
    localparam int CNT_W      = SEAT_IDX_W + 1;   // must hold the value NUM_SEATS
    localparam int STUDENT_W  = 32;
    localparam int TIME_W     = 11;

    localparam logic [SEAT_IDX_W-1:0] LAST_SEAT = SEAT_IDX_W'(NUM_SEATS - 1);

    // Effective state of a seat after the reservation timeout is applied.
    typedef enum logic [1:0] {
        SEAT_EMPTY    = 2'd0,
        SEAT_RESERVED = 2'd1,
        SEAT_OCCUPIED = 2'd2
    } seat_state_e;

    // Reader control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        QUERY = 2'd2,
        DONE  = 2'd3
    } fsm_state_e;

endpackage

// File: rtl/seat_classify.sv
// -----------------------------------------------------------------------------
// seat_classify
// Purely combinational mapping from one raw seat-table entry to its effective
// state and the remaining reservation time.
//
// Ports:
//   raw_state  in  [1:0]     stored seat state (0 empty, 1 reserved, 2/3 occupied)
//   seat_time  in  [TIME_W]  time stamp stored with the seat
//   cur_time   in  [TIME_W]  current time
//   limit_time in  [TIME_W]  reservation timeout
//   eff_state  out enum      effective state (expired reservations read as empty)
//   remain     out [TIME_W]  limit_time - elapsed for a live reservation, else 0
// -----------------------------------------------------------------------------
module seat_classify
    import seat_pkg::*;
(
    input  logic [1:0]        raw_state,
    input  logic [TIME_W-1:0] seat_time,
    input  logic [TIME_W-1:0] cur_time,
    input  logic [TIME_W-1:0] limit_time,
    output seat_state_e       eff_state,
    output logic [TIME_W-1:0] remain
);

    logic [TIME_W-1:0] elapsed;

    // The time counter wraps, so the modulo-2^TIME_W difference is the true
    // elapsed time as long as a reservation is younger than one wrap period.
    assign elapsed = cur_time - seat_time;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        eff_state = SEAT_EMPTY;
        remain    = '0;
        case (raw_state)
            2'd0: ;
            2'd1: begin
                if (elapsed <= limit_time) begin
                    eff_state = SEAT_RESERVED;
                    remain    = limit_time - elapsed;
                end
            end
            default: eff_state = SEAT_OCCUPIED;
        endcase
    end

endmodule

// File: rtl/seat_reader.sv
// -----------------------------------------------------------------------------
// seat_reader
// Reads an external 32-entry seat table. A scan walks every seat and reports
// effective empty/reserved/occupied counts plus the lowest empty seat; a query
// reads one seat and reports its student, effective state and remaining time.
// The table has a one-cycle read latency: data for a read issued in one cycle is
// consumed on the following rising edge.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   scan_req                       start a full scan (wins over query_req)
//   query_req, query_seat          single-seat lookup and its index
//   cur_time, limit_time           current time and reservation timeout
//   rd_en, rd_addr                 table read request / index
//   rd_student, rd_time, rd_state  table read data, one cycle after rd_en
//   busy, done                     operation in progress / scan-complete pulse
//   empty_cnt, reserved_cnt, occupied_cnt   scan results
//   first_free, free_valid         lowest empty seat and its qualifier
//   q_student, q_state, q_remain, q_valid   query result and its pulse
// -----------------------------------------------------------------------------
module seat_reader
    import seat_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_req,
    input  logic                  query_req,
    input  logic [SEAT_IDX_W-1:0] query_seat,
    input  logic [TIME_W-1:0]     cur_time,
    input  logic [TIME_W-1:0]     limit_time,
    output logic                  rd_en,
    output logic [SEAT_IDX_W-1:0] rd_addr,
    input  logic [STUDENT_W-1:0]  rd_student,
    input  logic [TIME_W-1:0]     rd_time,
    input  logic [1:0]            rd_state,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      empty_cnt,
    output logic [CNT_W-1:0]      reserved_cnt,
    output logic [CNT_W-1:0]      occupied_cnt,
    output logic [SEAT_IDX_W-1:0] first_free,
    output logic                  free_valid,
    output logic [STUDENT_W-1:0]  q_student,
    output logic [1:0]            q_state,
    output logic [TIME_W-1:0]     q_remain,
    output logic                  q_valid
);

    fsm_state_e            state;
    logic                  data_vld;   // rd_* carries data for a read issued last cycle
    logic [SEAT_IDX_W-1:0] data_idx;   // seat index that data belongs to

    logic [CNT_W-1:0]      acc_empty, acc_reserved, acc_occupied;
    logic                  ff_found;
    logic [SEAT_IDX_W-1:0] ff_idx;

    seat_state_e           cls_state;
    logic [TIME_W-1:0]     cls_remain;

    seat_classify u_classify (
        .raw_state  (rd_state),
        .seat_time  (rd_time),
        .cur_time   (cur_time),
        .limit_time (limit_time),
        .eff_state  (cls_state),
        .remain     (cls_remain)
    );

    // Accumulator values including the seat whose data is on the bus now; on
    // the last seat these go straight to the outputs so all results land on
    // the same edge.
    logic                  is_empty;
    logic [CNT_W-1:0]      nxt_empty, nxt_reserved, nxt_occupied;
    logic                  nxt_found;
    logic [SEAT_IDX_W-1:0] nxt_ff;

    assign is_empty     = (cls_state == SEAT_EMPTY);
    assign nxt_empty    = acc_empty    + CNT_W'(is_empty);
    assign nxt_reserved = acc_reserved + CNT_W'(cls_state == SEAT_RESERVED);
    assign nxt_occupied = acc_occupied + CNT_W'(cls_state == SEAT_OCCUPIED);

    // Seats arrive in ascending order, so the first empty one seen is the lowest.
    always_comb begin
        nxt_found = ff_found;
        nxt_ff    = ff_idx;
        if (!ff_found && is_empty) begin
            nxt_found = 1'b1;
            nxt_ff    = data_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            data_vld     <= 1'b0;
            data_idx     <= '0;
            acc_empty    <= '0;
            acc_reserved <= '0;
            acc_occupied <= '0;
            ff_found     <= 1'b0;
            ff_idx       <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            empty_cnt    <= '0;
            reserved_cnt <= '0;
            occupied_cnt <= '0;
            first_free   <= '0;
            free_valid   <= 1'b0;
            q_student    <= '0;
            q_state      <= '0;
            q_remain     <= '0;
            q_valid      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here
            // updates from pre-edge values regardless of statement order.
            done    <= 1'b0;
            q_valid <= 1'b0;
            case (state)
                IDLE: begin
                    data_vld <= 1'b0;
                    if (scan_req) begin
                        state        <= SCAN;
                        busy         <= 1'b1;
                        rd_en        <= 1'b1;
                        rd_addr      <= '0;
                        acc_empty    <= '0;
                        acc_reserved <= '0;
                        acc_occupied <= '0;
                        ff_found     <= 1'b0;
                        ff_idx       <= '0;
                    end else if (query_req) begin
                        state   <= QUERY;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= query_seat;
                    end
                end

                SCAN: begin
                    data_vld <= rd_en;
                    data_idx <= rd_addr;
                    if (rd_en) begin
                        if (rd_addr == LAST_SEAT) rd_en   <= 1'b0;
                        else                      rd_addr <= rd_addr + SEAT_IDX_W'(1);
                    end
                    if (data_vld) begin
                        acc_empty    <= nxt_empty;
                        acc_reserved <= nxt_reserved;
                        acc_occupied <= nxt_occupied;
                        ff_found     <= nxt_found;
                        ff_idx       <= nxt_ff;
                        if (data_idx == LAST_SEAT) begin
                            empty_cnt    <= nxt_empty;
                            reserved_cnt <= nxt_reserved;
                            occupied_cnt <= nxt_occupied;
                            first_free   <= nxt_ff;
                            free_valid   <= nxt_found;
                            done         <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end

                QUERY: begin
                    rd_en    <= 1'b0;
                    data_vld <= rd_en;
                    if (data_vld) begin
                        q_state   <= cls_state;
                        q_remain  <= cls_remain;
                        q_student <= is_empty ? '0 : rd_student;
                        q_valid   <= 1'b1;
                        state     <= DONE;
                    end
                end

                // Result pulse cycle; busy stays high through it.
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seat_reader.sv
// -----------------------------------------------------------------------------
// tb_seat_reader
// Self-checking bench for seat_reader. Emulates the seat table with one-cycle
// read latency and compares scan/query results against a behavioural model
// computed straight from the seat classification rules.
// -----------------------------------------------------------------------------
module tb_seat_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_req, query_req;
    logic [4:0]  query_seat;
    logic [10:0] cur_time, limit_time;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_student;
    logic [10:0] rd_time;
    logic [1:0]  rd_state;
    logic        busy, done;
    logic [5:0]  empty_cnt, reserved_cnt, occupied_cnt;
    logic [4:0]  first_free;
    logic        free_valid;
    logic [31:0] q_student;
    logic [1:0]  q_state;
    logic [10:0] q_remain;
    logic        q_valid;

    int n_vec = 0;
    int n_err = 0;

    // Last expected scan results, used to confirm they hold between scans.
    int last_e, last_r, last_o, last_ff, last_fv;

    seat_reader dut (
        .clk          (clk),
        .rst          (rst),
        .scan_req     (scan_req),
        .query_req    (query_req),
        .query_seat   (query_seat),
        .cur_time     (cur_time),
        .limit_time   (limit_time),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_student   (rd_student),
        .rd_time      (rd_time),
        .rd_state     (rd_state),
        .busy         (busy),
        .done         (done),
        .empty_cnt    (empty_cnt),
        .reserved_cnt (reserved_cnt),
        .occupied_cnt (occupied_cnt),
        .first_free   (first_free),
        .free_valid   (free_valid),
        .q_student    (q_student),
        .q_state      (q_state),
        .q_remain     (q_remain),
        .q_valid      (q_valid)
    );

    always #5 clk = ~clk;

    // Seat table: data for a read appears one cycle later; otherwise the bus
    // carries junk so a mistimed capture shows up.
    logic [31:0] tbl_student [32];
    logic [10:0] tbl_time    [32];
    logic [1:0]  tbl_state   [32];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_student <= tbl_student[rd_addr];
            rd_time    <= tbl_time[rd_addr];
            rd_state   <= tbl_state[rd_addr];
        end else begin
            rd_student <= $urandom;
            rd_time    <= 11'($urandom);
            rd_state   <= 2'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Behavioural model of one seat: effective state 0/1/2 and remaining time.
    function automatic void model_seat(input int i, output int st, output int rem);
        int elapsed;
        elapsed = (int'(cur_time) - int'(tbl_time[i]) + 2048) % 2048;
        st  = 0;
        rem = 0;
        if (tbl_state[i] >= 2) st = 2;
        else if (tbl_state[i] == 1 && elapsed <= int'(limit_time)) begin
            st  = 1;
            rem = int'(limit_time) - elapsed;
        end
    endfunction

    function automatic void model_scan(output int e, output int r, output int o,
                                       output int ff, output int fv);
        int st, rem;
        e = 0; r = 0; o = 0; ff = 0; fv = 0;
        for (int i = 0; i < 32; i++) begin
            model_seat(i, st, rem);
            if (st == 0) begin
                if (fv == 0) ff = i;
                fv = 1;
                e++;
            end else if (st == 1) r++;
            else o++;
        end
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 32; i++) begin
            tbl_student[i] = 32'd0;
            tbl_time[i]    = 11'd0;
            tbl_state[i]   = 2'd0;
        end
    endtask

    task automatic fill_random();
        cur_time   = 11'($urandom);
        limit_time = 11'($urandom_range(0, 200));
        for (int i = 0; i < 32; i++) begin
            tbl_student[i] = $urandom;
            tbl_state[i]   = 2'($urandom);
            if ($urandom_range(0, 3) == 0) tbl_time[i] = 11'($urandom);
            else tbl_time[i] = cur_time - 11'($urandom_range(0, int'(limit_time) + 3));
        end
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_empty"},    32'(empty_cnt),    32'(last_e));
        check({tag, "_reserved"}, 32'(reserved_cnt), 32'(last_r));
        check({tag, "_occupied"}, 32'(occupied_cnt), 32'(last_o));
        check({tag, "_first"},    32'(first_free),   32'(last_ff));
        check({tag, "_fvalid"},   32'(free_valid),   32'(last_fv));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     32'(busy),         0);
        check({tag, "_done"},     32'(done),         0);
        check({tag, "_rd_en"},    32'(rd_en),        0);
        check({tag, "_rd_addr"},  32'(rd_addr),      0);
        check({tag, "_counts"},   32'({empty_cnt, reserved_cnt, occupied_cnt}), 0);
        check({tag, "_free"},     32'({first_free, free_valid}), 0);
        check({tag, "_q_student"},q_student,         0);
        check({tag, "_q_misc"},   32'({q_state, q_remain, q_valid}), 0);
    endtask

    // Full scan; optionally with a same-cycle query that must be dropped.
    task automatic run_scan(input string tag, input bit with_query);
        int edges, nrd, nq;
        model_scan(last_e, last_r, last_o, last_ff, last_fv);
        @(negedge clk);
        scan_req   = 1'b1;
        query_req  = with_query;
        query_seat = 5'($urandom);
        @(posedge clk);               // acceptance edge
        @(negedge clk);
        scan_req  = 1'b0;
        query_req = 1'b0;
        edges = 0; nrd = 0; nq = 0;
        while (!done && edges < 40) begin
            if (rd_en) begin
                check({tag, "_rd_addr"}, 32'(rd_addr), nrd);
                nrd++;
            end
            check({tag, "_busy_run"}, 32'(busy), 1);
            if (q_valid) nq++;
            @(negedge clk);
            edges++;
        end
        check({tag, "_done_edge"}, edges, 33);
        check({tag, "_n_reads"},   nrd, 32);
        check({tag, "_no_qvalid"}, nq, 0);
        check({tag, "_busy_done"}, 32'(busy), 1);
        check_hold(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_rd_en_after"}, 32'(rd_en), 0);
    endtask

    task automatic run_query(input string tag, input int seat);
        int edges, st, rem, stu;
        model_seat(seat, st, rem);
        stu = (st == 0) ? 0 : int'(tbl_student[seat]);
        @(negedge clk);
        query_req  = 1'b1;
        query_seat = 5'(seat);
        @(posedge clk);               // acceptance edge
        @(negedge clk);
        query_req = 1'b0;
        check({tag, "_rd_en"},   32'(rd_en), 1);
        check({tag, "_rd_addr"}, 32'(rd_addr), seat);
        edges = 0;
        while (!q_valid && edges < 10) begin
            check({tag, "_busy_run"}, 32'(busy), 1);
            @(negedge clk);
            edges++;
        end
        check({tag, "_qvalid_edge"}, edges, 2);
        check({tag, "_busy_qv"},     32'(busy), 1);
        check({tag, "_q_state"},     32'(q_state), st);
        check({tag, "_q_remain"},    32'(q_remain), rem);
        check({tag, "_q_student"},   q_student, stu);
        @(negedge clk);
        check({tag, "_qvalid_pulse"}, 32'(q_valid), 0);
        check({tag, "_busy_after"},   32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        rst        = 1'b1;
        scan_req   = 1'b0;
        query_req  = 1'b0;
        query_seat = 5'd0;
        cur_time   = 11'd0;
        limit_time = 11'd0;
        clear_table();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // All-zero table: everything empty, first free seat 0.
        run_scan("zero_tbl", 1'b0);

        // Five occupied seats then a live reservation.
        clear_table();
        for (int i = 0; i < 5; i++) tbl_state[i] = 2'd2;
        tbl_state[5] = 2'd1;
        tbl_time[5]  = 11'd100;
        cur_time     = 11'd150;
        limit_time   = 11'd60;
        run_scan("mixed", 1'b0);

        // Scan and query in the same cycle: scan wins, query dropped.
        run_scan("scan_vs_query", 1'b1);

        // Reservation across the time wrap.
        clear_table();
        tbl_state[3]   = 2'd1;
        tbl_time[3]    = 11'd2040;
        tbl_student[3] = 32'hCAFE_0003;
        cur_time       = 11'd10;
        limit_time     = 11'd30;
        run_query("wrap", 3);
        check_hold("hold_after_query");

        // Expired reservation reads as empty.
        tbl_state[0]   = 2'd1;
        tbl_time[0]    = 11'd0;
        tbl_student[0] = 32'hDEAD_BEEF;
        cur_time       = 11'd100;
        limit_time     = 11'd50;
        run_query("expired", 0);

        // Timeout boundary: elapsed == limit still reserved, limit+1 expired.
        tbl_state[7] = 2'd1; tbl_time[7] = 11'd50; tbl_student[7] = 32'h7;
        tbl_state[8] = 2'd1; tbl_time[8] = 11'd49; tbl_student[8] = 32'h8;
        run_query("limit_edge", 7);
        run_query("limit_over", 8);

        // Fully occupied table.
        for (int i = 0; i < 32; i++) begin
            tbl_state[i]   = 2'(2 + (i % 2));
            tbl_student[i] = 32'(i + 1000);
        end
        run_scan("all_occ", 1'b0);
        run_query("occ_query", 31);

        // Randomized rounds.
        for (int t = 0; t < 8; t++) begin
            fill_random();
            run_scan("rand_scan", 1'b0);
            for (int k = 0; k < 5; k++) run_query("rand_query", $urandom_range(0, 31));
            check_hold("rand_hold");
        end

        // Reset in the middle of a scan: aborted with no done, outputs cleared.
        fill_random();
        @(negedge clk);
        scan_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        scan_req = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || q_valid) dones++;
        end
        check("mid_rst_no_pulse", dones, 0);
        check_zero("mid_rst_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
